v_ce_burst_gen: RTL and testbench
=================================

V_CE_BURST_GEN -- requirements
Module: v_ce_burst_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, setting the width of DIV, LEN and the internal counters.
REQ-002 SHALL have port C, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port CLR, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port START, input, 1 bit: request to begin a burst, sampled in IDLE only.
REQ-005 SHALL have port STOP, input, 1 bit: abort the burst in progress.
REQ-006 SHALL have port DIV, input, WIDTH bits: idle cycles between CE pulses, so the CE period is DIV+1.
REQ-007 SHALL have port LEN, input, WIDTH bits: number of CE pulses per burst.
REQ-008 SHALL have port CE, output, 1 bit: registered clock-enable pulse feeding the downstream CE-gated register stage.
REQ-009 SHALL have port BUSY, output, 1 bit: high while a burst is active.
REQ-010 SHALL have port DONE, output, 1 bit: one-cycle pulse on normal burst completion.

Function
REQ-011 SHALL implement FSM states IDLE, RUN and FIN, with all outputs registered.
REQ-012 SHALL capture DIV and LEN in IDLE in the cycle START=1 is sampled (cycle t); later input changes SHALL NOT affect the active burst.
REQ-013 SHALL, when START is sampled with captured LEN>0, enter RUN, hold BUSY=1 from cycle t+1, and drive the first CE high in cycle t+1+DIV.
REQ-014 SHALL space successive CE pulses exactly DIV+1 cycles apart, each CE high for exactly one cycle; DIV=0 SHALL give LEN contiguous CE cycles.
REQ-015 SHALL, after the LEN-th CE cycle, enter FIN for one cycle with DONE=1, BUSY=0 and CE=0, then return to IDLE.
REQ-016 SHALL, when START is sampled with LEN=0, go directly to FIN: DONE=1 in cycle t+1, with no CE and no BUSY.
REQ-017 SHALL ignore START while in RUN or FIN.
REQ-018 SHALL, when STOP=1 is sampled in RUN during cycle k, force CE=0 and BUSY=0 from cycle k+1, return to IDLE and produce no DONE.
REQ-019 SHALL give STOP priority when STOP and START are both 1 in IDLE, so the block stays in IDLE.
REQ-020 SHALL give a STOP sampled in the same cycle as the final CE priority, so no DONE follows.
REQ-021 SHALL use modulo-2^WIDTH unsigned counters that never wrap during a legal burst; the maximum burst is 2^WIDTH-1 pulses with period 2^WIDTH.
REQ-022 SHALL accept a new START in the IDLE cycle immediately following FIN.

Reset
REQ-023 SHALL, while CLR=0, asynchronously force state=IDLE, CE=0, BUSY=0, DONE=0 and clear all counters and captured values.
REQ-024 SHALL, when CLR is asserted mid-burst, abort the burst immediately with no DONE; after CLR deasserts, the block SHALL remain in IDLE until a new START.

Configuration
REQ-025 SHALL, when macro V_CE_BURST_GEN_REMAIN_EN is defined, add output REMAIN (WIDTH bits) showing the CE pulses not yet issued: LEN from cycle t+1, decremented in the cycle after each CE, 0 in IDLE, FIN and reset.
REQ-026 SHALL, without V_CE_BURST_GEN_REMAIN_EN, have no REMAIN port and otherwise identical behaviour.

Structure
REQ-027 SHALL take the FSM state encoding (IDLE, RUN, FIN) and the default WIDTH constant from shared package v_ce_burst_pkg.
REQ-028 SHALL place the period counter in sub-module v_ce_prescaler: load on start, count down, terminal-count flag at zero, reload to DIV on terminal count.

Verification
REQ-029 SHALL verify: DIV=2, LEN=3, START in cycle 10 -> CE high in cycles 13, 16, 19; BUSY high in cycles 11-19; DONE high in cycle 20 only.
REQ-030 SHALL verify: DIV=0, LEN=4, START in cycle 5 -> CE high in cycles 6-9; DONE high in cycle 10.
REQ-031 SHALL verify: LEN=0, START in cycle 3 -> DONE high in cycle 4; CE and BUSY never high.
REQ-032 SHALL verify: DIV=1, LEN=5, START in cycle 0, STOP in cycle 4 -> CE high in cycles 2 and 4 only; BUSY low from cycle 5; no DONE.
REQ-033 SHALL verify: CLR low in cycle 7 of a DIV=3, LEN=8 burst -> CE, BUSY and DONE low immediately; no activity after release until a new START.
REQ-034 SHALL verify: START held high throughout a DIV=1, LEN=2 burst -> exactly one burst plus DONE, then a second burst starting from the IDLE cycle after FIN; REMAIN counts 2, 1, 0 when V_CE_BURST_GEN_REMAIN_EN is defined.

Source files
------------

// File: rtl/v_ce_burst_pkg.sv
// Shared FSM encoding and default width for the CE burst generator.
package v_ce_burst_pkg;
  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;
endpackage

// File: rtl/v_ce_prescaler.sv
// CE period counter: loads DIV on start, counts down, reloads the captured
// DIV at terminal count. tc_o is the terminal-count flag of the next cycle.
module v_ce_prescaler
  import v_ce_burst_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] div_i,
  output logic             tc_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             tc;

  assign tc = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    if (load_i) begin
      cnt_d = div_i;
      div_d = div_i;
    end else if (en_i) begin
      cnt_d = tc ? div_q : cnt_q - WIDTH'(1);
    end
  end

  // Looking at cnt_d lets the parent register CE in the same cycle the count hits zero.
  assign tc_o = (cnt_d == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end
endmodule

// File: rtl/v_ce_burst_gen.sv
// Burst clock-enable generator: LEN CE pulses spaced DIV+1 cycles apart.
// Optional REMAIN output enabled by macro V_CE_BURST_GEN_REMAIN_EN.
module v_ce_burst_gen
  import v_ce_burst_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             START,
  input  logic             STOP,
  input  logic [WIDTH-1:0] DIV,
  input  logic [WIDTH-1:0] LEN,
  output logic             CE,
  output logic             BUSY,
`ifdef V_CE_BURST_GEN_REMAIN_EN
  output logic [WIDTH-1:0] REMAIN,
`endif
  output logic             DONE
);
  state_e           state_q, state_d;
  logic             ce_q, ce_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             ps_load, ps_en, ps_tc;

  assign ps_load = (state_q == IDLE) && START && !STOP && (LEN != '0);
  assign ps_en   = (state_q == RUN);

  v_ce_prescaler #(.WIDTH(WIDTH)) u_ps (
    .clk_i  (C),
    .rst_ni (CLR),
    .load_i (ps_load),
    .en_i   (ps_en),
    .div_i  (DIV),
    .tc_o   (ps_tc)
  );

  always_comb begin
    state_d = state_q;
    ce_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        rem_d = '0;
        if (START && !STOP) begin
          if (LEN == '0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
            ce_d    = ps_tc;
            rem_d   = LEN;
          end
        end
      end
      RUN: begin
        if (STOP) begin
          state_d = IDLE;
          rem_d   = '0;
        end else if (ce_q && (rem_q == WIDTH'(1))) begin
          state_d = FIN;
          done_d  = 1'b1;
          rem_d   = '0;
        end else begin
          busy_d = 1'b1;
          ce_d   = ps_tc;
          if (ce_q) rem_d = rem_q - WIDTH'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge C or negedge CLR) begin
    if (!CLR) begin
      state_q <= IDLE;
      ce_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ce_q    <= ce_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rem_q   <= rem_d;
    end
  end

  assign CE   = ce_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
`ifdef V_CE_BURST_GEN_REMAIN_EN
  assign REMAIN = rem_q;
`endif
endmodule

// File: tb/tb_v_ce_burst_gen.sv
// Table-driven bench for v_ce_burst_gen with a per-cycle expectation queue.
module tb_v_ce_burst_gen;
  localparam int NC = 24;

  typedef struct packed {
    logic [7:0]  div;
    logic [7:0]  len;
    logic [31:0] start;
    logic [31:0] stop;
    logic [31:0] ce;
    logic [31:0] busy;
    logic [31:0] done;
  } vec_t;

  typedef struct packed {
    logic ce;
    logic busy;
    logic done;
  } obs_t;

  logic       C = 1'b0;
  logic       CLR = 1'b0;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic [7:0] DIV = '0;
  logic [7:0] LEN = '0;
  logic       CE, BUSY, DONE;
`ifdef V_CE_BURST_GEN_REMAIN_EN
  logic [7:0] REMAIN;
`endif

  int n_vec = 0;
  int n_mis = 0;
  obs_t sb[$];
  vec_t vecs[8];

  v_ce_burst_gen #(.WIDTH(8)) dut (
    .C     (C),
    .CLR   (CLR),
    .START (START),
    .STOP  (STOP),
    .DIV   (DIV),
    .LEN   (LEN),
    .CE    (CE),
    .BUSY  (BUSY),
`ifdef V_CE_BURST_GEN_REMAIN_EN
    .REMAIN(REMAIN),
`endif
    .DONE  (DONE)
  );

  always #5 C = ~C;

  task automatic chk(input string nm, input int cyc, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s cyc%0d got=%b expected=%b", nm, cyc, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge C);
    START = 1'b0;
    STOP  = 1'b0;
    CLR   = 1'b0;
    #1;
    chk("reset ce/busy/done", 0, {5'd0, CE, BUSY, DONE}, 8'd0);
`ifdef V_CE_BURST_GEN_REMAIN_EN
    chk("reset remain", 0, REMAIN, 8'd0);
`endif
    repeat (2) @(posedge C);
    @(negedge C);
    CLR = 1'b1;
  endtask

  // Cycle n: inputs driven #1 after edge n, outputs sampled at the following negedge.
  task automatic drive_cycle(input vec_t v, input int n);
    obs_t e;
    @(posedge C);
    #1;
    START = v.start[n];
    STOP  = v.stop[n];
    if (v.start[n]) begin
      DIV = v.div;
      LEN = v.len;
    end else begin
      DIV = 8'($urandom);
      LEN = 8'($urandom);
    end
    e.ce = v.ce[n]; e.busy = v.busy[n]; e.done = v.done[n];
    sb.push_back(e);
  endtask

  task automatic sample_cycle(input int id, input int n);
    obs_t e;
    @(negedge C);
    e = sb.pop_front();
    chk($sformatf("vec%0d ce/busy/done", id), n, {5'd0, CE, BUSY, DONE}, {5'd0, e});
  endtask

  initial begin
    //           div    len    start          stop          ce             busy           done
    vecs[0] = '{8'd2, 8'd3, 32'h0000_0400, 32'h0,       32'h0009_2000, 32'h000F_F800, 32'h0010_0000};
    vecs[1] = '{8'd0, 8'd4, 32'h0000_0020, 32'h0,       32'h0000_03C0, 32'h0000_03C0, 32'h0000_0400};
    vecs[2] = '{8'd5, 8'd0, 32'h0000_0008, 32'h0,       32'h0,         32'h0,         32'h0000_0010};
    vecs[3] = '{8'd1, 8'd5, 32'h0000_0001, 32'h10,      32'h0000_0014, 32'h0000_001E, 32'h0};
    vecs[4] = '{8'd1, 8'd2, 32'h00FF_FFFF, 32'h0,       32'h0051_4514, 32'h0079_E79E, 32'h0082_0820};
    vecs[5] = '{8'd2, 8'd3, 32'h0000_0004, 32'h4,       32'h0,         32'h0,         32'h0};
    vecs[6] = '{8'd0, 8'd3, 32'h0000_0002, 32'h10,      32'h0000_001C, 32'h0000_001C, 32'h0};
    vecs[7] = '{8'd3, 8'd1, 32'h0000_0001, 32'h0,       32'h0000_0010, 32'h0000_001E, 32'h0000_0020};

    for (int i = 0; i < 8; i++) begin
      do_reset();
      for (int n = 0; n < NC; n++) begin
        drive_cycle(vecs[i], n);
        sample_cycle(i, n);
      end
    end

    // Reset mid-burst: DIV=3 LEN=8 started in cycle 0, CLR pulled low in cycle 7.
    begin
      vec_t v;
      v = '{8'd3, 8'd8, 32'h1, 32'h0, 32'h0000_0010, 32'h0000_00FE, 32'h0};
      do_reset();
      for (int n = 0; n < 7; n++) begin
        drive_cycle(v, n);
        sample_cycle(8, n);
      end
      @(posedge C);
      #1;
      START = 1'b0;
      #2;
      CLR = 1'b0;
      #1;
      chk("clr mid-burst", 7, {5'd0, CE, BUSY, DONE}, 8'd0);
      @(negedge C);
      CLR = 1'b1;
      v = '{8'd3, 8'd8, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      for (int n = 8; n < 20; n++) begin
        drive_cycle(v, n);
        sample_cycle(9, n);
      end
    end

`ifdef V_CE_BURST_GEN_REMAIN_EN
    begin
      vec_t v;
      logic [7:0] rexp [7];
      rexp = '{8'd0, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0};
      v = '{8'd1, 8'd2, 32'h1, 32'h0, 32'h14, 32'h1E, 32'h20};
      do_reset();
      for (int n = 0; n < 7; n++) begin
        drive_cycle(v, n);
        @(negedge C);
        void'(sb.pop_front());
        chk("remain", n, REMAIN, rexp[n]);
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
